// File: rtl/mycpu_io_port.sv
// mycpu I/O-bus responder: data register backed by TX/RX FIFOs plus a status register.
// Define MYCPU_IO_ERRFLAG_EN to build the sticky tx_overflow / rx_underflow flags.
module mycpu_io_port #(
    parameter logic [15:0] BASE_ADDR = 16'h00F0,
    parameter int          DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] a_out,
    input  logic [15:0] d_out,
    input  logic        wen_out,
    input  logic        iom_out,
    output logic [15:0] io_in,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [15:0] rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [3:0]  FULL_CNT  = 4'(DEPTH);
    localparam logic [15:0] STAT_ADDR = BASE_ADDR + 16'd1;

    // Both streaming sides use valid/ready: a word moves on a rising edge
    // where valid and ready are both high; valid must not depend on ready.

    logic [15:0]   tx_mem [DEPTH];
    logic [15:0]   rx_mem [DEPTH];
    logic [AW-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
    logic [3:0]    tx_count, rx_count, tx_count_nxt, rx_count_nxt;
    logic          rx_ready_q;
    logic          tx_ovf, rx_udf;

    logic hit_data, hit_stat;
    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_push_req, tx_push, tx_pop;
    logic rx_pop_req, rx_pop, rx_push;
    logic [15:0] status;

    assign hit_data = iom_out && (a_out == BASE_ADDR);
    assign hit_stat = iom_out && (a_out == STAT_ADDR);

    assign tx_full  = (tx_count == FULL_CNT);
    assign tx_empty = (tx_count == 4'd0);
    assign rx_full  = (rx_count == FULL_CNT);
    assign rx_empty = (rx_count == 4'd0);

    // Fullness/emptiness are taken from the registered counts, so a drain or
    // fill in the same cycle never rescues a write to full or a read of empty.
    assign tx_push_req = hit_data && !wen_out;
    assign tx_push     = tx_push_req && !tx_full;
    assign tx_pop      = tx_valid && tx_ready;
    assign rx_pop_req  = hit_data && wen_out;
    assign rx_pop      = rx_pop_req && !rx_empty;
    assign rx_push     = rx_valid && rx_ready_q;

    assign tx_count_nxt = tx_count + {3'b000, tx_push} - {3'b000, tx_pop};
    assign rx_count_nxt = rx_count + {3'b000, rx_push} - {3'b000, rx_pop};

    assign tx_valid = !tx_empty;
    assign tx_data  = tx_valid ? tx_mem[tx_rd] : 16'h0000;
    assign rx_ready = rx_ready_q;

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr] <= d_out;
        if (rx_push) rx_mem[rx_wr] <= rx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr      <= '0;
            tx_rd      <= '0;
            rx_wr      <= '0;
            rx_rd      <= '0;
            tx_count   <= 4'd0;
            rx_count   <= 4'd0;
            rx_ready_q <= 1'b0;
        end else begin
            if (tx_push) tx_wr <= tx_wr + AW'(1);
            if (tx_pop)  tx_rd <= tx_rd + AW'(1);
            if (rx_push) rx_wr <= rx_wr + AW'(1);
            if (rx_pop)  rx_rd <= rx_rd + AW'(1);
            tx_count   <= tx_count_nxt;
            rx_count   <= rx_count_nxt;
            rx_ready_q <= (rx_count_nxt < FULL_CNT);
        end
    end

`ifdef MYCPU_IO_ERRFLAG_EN
    logic stat_wr;
    assign stat_wr = hit_stat && !wen_out;

    // Set has priority over a clear arriving in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_ovf <= 1'b0;
            rx_udf <= 1'b0;
        end else begin
            if (tx_push_req && tx_full) tx_ovf <= 1'b1;
            else if (stat_wr)           tx_ovf <= 1'b0;
            if (rx_pop_req && rx_empty) rx_udf <= 1'b1;
            else if (stat_wr)           rx_udf <= 1'b0;
        end
    end
`else
    assign tx_ovf = 1'b0;
    assign rx_udf = 1'b0;
`endif

    assign status = {rx_count, tx_count, 2'b00, rx_udf, tx_ovf,
                     rx_empty, rx_full, tx_empty, tx_full};

    always_comb begin
        io_in = 16'h0000;
        if (rst_n) begin
            if (hit_data && wen_out && !rx_empty) io_in = rx_mem[rx_rd];
            else if (hit_stat && wen_out)         io_in = status;
        end
    end

endmodule

// File: doc/mycpu_io_port.md
# mycpu_io_port

Memory-mapped I/O responder on the mycpu I/O bus. It decodes CPU I/O cycles (`iom_out` high) and serves two registers: a data register and a status register. OUT cycles push words into a transmit FIFO that drains to an external valid/ready consumer. IN cycles pop words from a receive FIFO filled by an external valid/ready producer. It replaces the behavioural I/O model in `mycpu_test` and sits beside the memory model, on the same CPU-side nets as `mycpu`.

## Interface
Parameters:
- `BASE_ADDR`, default 16'h00F0: I/O address of the data register. The status register is at `BASE_ADDR+1`.
- `DEPTH`, default 4: entries per FIFO; a power of two, 2..8.

Ports:
- `clk`  input  1: single clock; all state changes on the rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `a_out`  input  16: CPU address.
- `d_out`  input  16: CPU write data.
- `wen_out`  input  1: CPU write enable, active low. 0 = OUT/write cycle, 1 = IN/read cycle.
- `iom_out`  input  1: 1 = I/O cycle, 0 = memory cycle (ignored by this block).
- `io_in`  output  16: read data returned to the CPU.
- `tx_data`  output  16: head of the TX FIFO.
- `tx_valid`  output  1: TX FIFO not empty.
- `tx_ready`  input  1: consumer accepts `tx_data`.
- `rx_data`  input  16: producer word.
- `rx_valid`  input  1: producer word valid.
- `rx_ready`  output  1: RX FIFO can accept a word (registered).

## Operation
Cycle decode, evaluated only when `iom_out`=1:
- Write to data register (`a_out`=BASE_ADDR, `wen_out`=0): push `d_out` into the TX FIFO.
- Read of data register (`wen_out`=1): `io_in` shows the RX head and the entry is popped at the edge.
- Write to status (`a_out`=BASE_ADDR+1, `wen_out`=0): clears the sticky flags (see Configuration).
- Any other address, or `iom_out`=0: no state change and `io_in`=16'h0000.

Status word, read at BASE_ADDR+1:
- [0] tx_full
- [1] tx_empty
- [2] rx_full
- [3] rx_empty
- [4] tx_overflow
- [5] rx_underflow
- [7:6] 0
- [11:8] tx_count
- [15:12] rx_count

Boundary conditions:
- **Write to a full TX FIFO:** the word is dropped and tx_overflow is set. Fullness is judged at the start of the cycle, so a simultaneous `tx_valid`&`tx_ready` drain does not rescue the write.
- **Read of an empty RX FIFO:** `io_in`=16'h0000, no pop, and rx_underflow is set. A producer push in the same cycle still lands.
- **Push and pop in the same cycle on a non-full, non-empty FIFO:** both occur and the count is unchanged.
- **Pointers:** wrap modulo DEPTH. Counts are 4 bits and range 0..DEPTH.
- **`rx_ready`:** registered. Next value = 1 when rx_count after this edge is less than DEPTH.

## Timing
- **Reset:** asynchronous. It clears both FIFOs (counts 0, pointers 0) and both flags, and sets `rx_ready`=0.
  - Output values during reset: `io_in`=0, `tx_data`=0, `tx_valid`=0.
  - `rx_ready` rises on the first rising edge after `rst_n` deasserts.
- **`io_in`:** combinational from registered state and the current address and strobes. It is valid in the same cycle as the IN access, and the CPU samples it at that cycle's rising edge. Pop takes effect on the same edge.
- **OUT latency:** an OUT at edge N makes `tx_valid`=1 and `tx_data` equal to the word from cycle N+1 onward, if the FIFO was empty.
- **RX latency:** an `rx_valid`&`rx_ready` transfer at edge N is readable via IN from cycle N+1.
- **Back-to-back:** IN or OUT accesses on consecutive cycles are each serviced, one entry per cycle.
- **Reset mid-operation:** any contents in flight are discarded. No word is emitted after reset until a new OUT occurs.

## Configuration
`MYCPU_IO_ERRFLAG_EN`:
- **Defined:** tx_overflow and rx_underflow are sticky flags. They are set as described in Operation and cleared by any write to BASE_ADDR+1. If a set event and a clear occur in the same cycle, set wins.
- **Undefined:** status bits [5:4] read 0, no flag registers exist, and writes to BASE_ADDR+1 are ignored. Drop and no-pop behaviour is unchanged.

## Test plan
- **Basic OUT:** after reset, OUT 16'h1234 then 16'hBEEF with `tx_ready`=0, then `tx_ready`=1. Required: `tx_data` shows 1234 then BEEF on consecutive cycles, and `tx_valid` falls after the second transfer.
- **TX overflow:** with DEPTH=4 and `tx_ready`=0, issue 5 OUTs (values 1..5). Required: status reads tx_full=1 and tx_count=4; drain yields 1,2,3,4; tx_overflow=1 (macro defined) or bit4=0 (undefined).
- **RX full and underflow:** producer sends 16'hA5A5 and 16'h5A5A. Required:
  - IN reads return A5A5 then 5A5A.
  - A third IN returns 0000 with rx_empty=1 and rx_underflow=1.
  - A status write clears the flags.
  - Once rx_count reaches DEPTH, `rx_ready` drops.
- **Simultaneous access:** with RX count=1, an IN coincides with a producer push of 16'h0007. Required: count stays 1 and the next IN returns 0007.
- **Decode and reset:** IN/OUT to BASE_ADDR+2, and memory cycles at BASE_ADDR, cause no state change and `io_in`=0. Asserting `rst_n` low mid-drain clears `tx_valid` immediately and `rx_ready` returns one cycle after release.
